// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parametrised pipeline register chain with per-stage valid,
// stall and flush control, and an optional bubble-collapse mode.
//
// Every stage register updates on the falling edge of clk. rst is
// synchronous and active-high.
//
// Parameters:
//   WIDTH    - data width in bits
//   DEPTH    - number of register stages
//   RST_VAL  - value loaded into every data stage on reset/flush
//   COLLAPSE - 0: lock-step chain, 1: bubbles absorb upstream entries while stalled
//
// Ports:
//   clk       - clock (falling-edge active)
//   rst       - synchronous active-high reset
//   in_data   - data into stage 0
//   in_valid  - in_data qualifies an entry
//   in_ready  - entry accepted on this edge when in_valid & in_ready (combinational)
//   stall     - downstream cannot consume the last stage
//   flush     - discard all entries
//   out_data  - last-stage data (registered)
//   out_valid - last-stage valid (registered)
//   count     - number of valid stages (registered)
module pipe_reg_chain #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}},
    parameter bit               COLLAPSE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_r;
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [CW-1:0]    count_r;

    logic [DEPTH-1:0] adv_s;
    logic [DEPTH-1:0] load_s;
    logic [DEPTH-1:0] nxt_v_s;
    logic [WIDTH-1:0] nxt_data_s [DEPTH];
    logic             in_ready_s;
    logic             accept_s;

    // Number of set bits in a stage-valid vector.
    function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] vec);
        logic [CW-1:0] acc;
        acc = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (vec[i]) begin
                acc = acc + CW'(1'b1);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Advance/load chain: adv_s[i] means the content of stage i moves downstream
    // this edge; load_s[i] means stage i takes its upstream neighbour's content.
    always_comb begin
        adv_s             = {DEPTH{1'b0}};
        load_s            = {DEPTH{1'b0}};
        adv_s[DEPTH-1]    = ~stall;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (COLLAPSE) begin
                adv_s[i] = ~v_r[i+1] | adv_s[i+1];
            end else begin
                adv_s[i] = ~stall;
            end
        end
        // In collapse mode an empty stage can always be refilled, even when
        // nothing downstream of it moves; in lock-step mode only !stall moves.
        for (int i = 0; i < DEPTH; i++) begin
            if (COLLAPSE) begin
                load_s[i] = ~v_r[i] | adv_s[i];
            end else begin
                load_s[i] = ~stall;
            end
        end
    end

    // Input handshake: stage 0 accepts whenever it loads, never during flush.
    always_comb begin
        in_ready_s = load_s[0] & ~flush;
        accept_s   = in_valid & in_ready_s;
    end

    // Next-state valid and data for every stage; data holds when a bubble arrives.
    always_comb begin
        nxt_v_s = v_r;
        for (int i = 0; i < DEPTH; i++) begin
            nxt_data_s[i] = data_r[i];
        end
        if (load_s[0]) begin
            nxt_v_s[0] = accept_s;
            if (accept_s) begin
                nxt_data_s[0] = in_data;
            end else begin
                nxt_data_s[0] = data_r[0];
            end
        end else begin
            nxt_v_s[0]    = v_r[0];
            nxt_data_s[0] = data_r[0];
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (load_s[i]) begin
                nxt_v_s[i] = v_r[i-1];
                if (v_r[i-1]) begin
                    nxt_data_s[i] = data_r[i-1];
                end else begin
                    nxt_data_s[i] = data_r[i];
                end
            end else begin
                nxt_v_s[i]    = v_r[i];
                nxt_data_s[i] = data_r[i];
            end
        end
    end

    // Stage registers and occupancy count; reset and flush share one clear path.
    always_ff @(negedge clk) begin
        if (rst || flush) begin
            v_r     <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= RST_VAL;
            end
        end else begin
            v_r     <= nxt_v_s;
            count_r <= popcount(nxt_v_s);
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= nxt_data_s[i];
            end
        end
    end

    // Output mapping: all outputs except in_ready come straight from registers.
    always_comb begin
        in_ready  = in_ready_s;
        out_data  = data_r[DEPTH-1];
        out_valid = v_r[DEPTH-1];
        count     = count_r;
    end

endmodule
